load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the byte-lane memory.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req_valid  input  1  pipeline presents an access.
REQ-005 req_ready  output  1  unit accepts an access (IDLE only).
REQ-006 req_store  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address; any alignment legal.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  access complete.
REQ-011 resp_ready  input  1  pipeline takes the response.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  illegal funct3.
REQ-014 mem_address  output  32  byte address to memory.
REQ-015 mem_in  output  32  store data to memory.
REQ-016 mem_wren  output  1  memory write enable.
REQ-017 mem_width  output  2  width code: 00 byte, 01 half, 11 word.
REQ-018 mem_out  input  32  memory read data; the byte at mem_address sits in [31:24].

Function
REQ-019 SHALL implement the FSM IDLE -> ACCESS -> (store: DONE | load: READ -> DONE) -> IDLE.
REQ-020 IDLE: req_ready=1; req_valid&req_ready latches store, funct3, addr and wdata, then goes to ACCESS (legal) or DONE with resp_err=1 (illegal).
REQ-021 Illegal funct3: loads 011, 110, 111; stores any value above 010.
REQ-022 ACCESS: mem_address, mem_width and mem_in driven from latched fields; mem_wren=1 for stores only, for exactly this one cycle.
REQ-023 READ: mem_address and mem_width held unchanged; mem_out captured and extended into resp_rdata at the end of the cycle.
REQ-024 Load extraction: B/BU from mem_out[31:24]; H/HU from mem_out[31:16]; W uses the whole word.
REQ-025 Sign-extend B and H; zero-extend BU and HU.
REQ-026 Store data mapping: mem_in = req_wdata unchanged, with the memory taking byte [7:0] and half [15:0].
REQ-027 DONE: resp_valid=1 until resp_valid&resp_ready, then IDLE; resp_rdata and resp_err stay stable throughout.
REQ-028 Latency with acceptance at edge t:
- Load: resp_valid high after edge t+2.
- Store: resp_valid high after edge t+1; the memory write happens at edge t+1.
- Illegal: resp_valid high after edge t; no memory access.
REQ-029 Back-to-back operation: no new request is accepted in the cycle resp_valid&resp_ready completes; the next acceptance occurs in IDLE.
REQ-030 mem_wren SHALL be 0 in every state except ACCESS with a store.
REQ-031 Outside ACCESS/READ, mem_address, mem_width and mem_in hold their last values.

Reset
REQ-032 rst SHALL immediately set state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_address=0, mem_in=0, mem_width=11.
REQ-033 rst asserted mid-access SHALL abandon the access; mem_wren drops asynchronously and no response is produced.

Structure
REQ-034 Package lsu_pkg SHALL hold:
- width codes BYTE, HALF, WORD;
- funct3 constants;
- the FSM state enum.
REQ-035 Sub-module lsu_load_extend SHALL perform the combinational extraction and extension of mem_out by funct3.

Verification
REQ-036 LB at 0x103, mem_out=0x80123456 in READ -> resp_rdata=0xFFFFFF80, mem_width=00, resp_valid after edge t+2.
REQ-037 LHU at 0x2, mem_out=0xBEEF1234 -> resp_rdata=0x0000BEEF; LH with the same data -> 0xFFFFBEEF.
REQ-038 SW at 0x2, wdata=0xDEADBEEF -> mem_wren=1 for one cycle, mem_width=11, mem_in=0xDEADBEEF, resp_valid after edge t+1, resp_rdata=0.
REQ-039 Load with funct3=011 -> resp_err=1 after edge t, mem_wren never asserted, resp_rdata=0.
REQ-040 Backpressure and reset:
- resp_ready=0 for 4 cycles -> resp_valid and resp_rdata held, req_ready=0.
- rst pulsed in ACCESS of an SB -> mem_wren=0 immediately, IDLE, no response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory width codes, RISC-V
// funct3 encodings, the FSM state type and small decode helpers.
package lsu_pkg;

    // Width codes understood by the byte-lane memory
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b11;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        READ   = 2'b10,
        DONE   = 2'b11
    } lsu_state_e;

    // The low two funct3 bits select the access size for both loads and stores
    function automatic logic [1:0] width_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   width_of = BYTE;
            2'b01:   width_of = HALF;
            default: width_of = WORD;
        endcase
    endfunction

    // Stores have no unsigned variants, so anything above W is illegal;
    // loads reject 011 and the unused 11x encodings
    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        if (store)
            is_illegal = (funct3 > F3_W);
        else
            is_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational extraction of the addressed byte/half/word from the memory
// read word (addressed byte is in [31:24]) and sign/zero extension by funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_out,
    output logic [31:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = mem_out[31:24];
    assign half_val = mem_out[31:16];

    // Select the field and fill the upper bits with its sign or with zero
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'h0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'h0, half_val};
            F3_W:    load_data = mem_out;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time from the pipeline, drives a
// synchronous byte-lane memory and returns extended load data or an error.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_in,
    output logic        mem_wren,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_out
);

    lsu_state_e  state_reg;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_in_reg;
    logic        mem_wren_reg;
    logic [1:0]  mem_width_reg;
    logic [31:0] load_data;

    lsu_load_extend u_load_extend (
        .funct3    (funct3_reg),
        .mem_out   (mem_out),
        .load_data (load_data)
    );

    // Access sequencer; memory-side outputs are registered at acceptance so
    // they are valid throughout ACCESS and simply hold in every later state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            store_reg       <= 1'b0;
            funct3_reg      <= 3'b000;
            req_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_rdata_reg  <= 32'h0;
            mem_address_reg <= 32'h0;
            mem_in_reg      <= 32'h0;
            mem_wren_reg    <= 1'b0;
            mem_width_reg   <= WORD;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg      <= req_store;
                        funct3_reg     <= req_funct3;
                        resp_rdata_reg <= 32'h0;
                        req_ready_reg  <= 1'b0;
                        if (is_illegal(req_store, req_funct3)) begin
                            // Report immediately without touching memory
                            resp_err_reg   <= 1'b1;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= DONE;
                        end else begin
                            resp_err_reg    <= 1'b0;
                            mem_address_reg <= req_addr;
                            mem_width_reg   <= width_of(req_funct3);
                            mem_in_reg      <= req_wdata;
                            mem_wren_reg    <= req_store;
                            state_reg       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The store commits at the edge leaving ACCESS
                    mem_wren_reg <= 1'b0;
                    if (store_reg) begin
                        resp_valid_reg <= 1'b1;
                        state_reg      <= DONE;
                    end else begin
                        state_reg <= READ;
                    end
                end
                READ: begin
                    resp_rdata_reg <= load_data;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_err    = resp_err_reg;
    assign resp_rdata  = resp_rdata_reg;
    assign mem_address = mem_address_reg;
    assign mem_in      = mem_in_reg;
    assign mem_wren    = mem_wren_reg;
    assign mem_width   = mem_width_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses from the requirements followed
// by randomized loads/stores, checked against a behavioural model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_in;
    logic        mem_wren;
    logic [1:0]  mem_width;
    logic [31:0] mem_out;

    int passed = 0;
    int total  = 0;

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_wren    (mem_wren),
        .mem_width   (mem_width),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: legality from the funct3 table
    function automatic bit ref_illegal(input bit st, input int f3);
        if (st) return !(f3 == 0 || f3 == 1 || f3 == 2);
        return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    endfunction

    // Reference: width code from access size in bytes
    function automatic logic [31:0] ref_width(input int f3);
        int size;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return (size == 1) ? 32'd0 : (size == 2) ? 32'd1 : 32'd3;
    endfunction

    // Reference: take the leading byte(s) of the memory word and extend arithmetically
    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] m);
        longint v;
        case (f3)
            0: begin v = longint'(m / 32'h0100_0000); if (v > 127)   v = v - 256;   end
            4: v = longint'(m / 32'h0100_0000);
            1: begin v = longint'(m / 32'h0001_0000); if (v > 32767) v = v - 65536; end
            5: v = longint'(m / 32'h0001_0000);
            default: v = longint'(m);
        endcase
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access: issue, follow the FSM cycle by cycle, stall the
    // response for 'hold' cycles, then complete the handshake
    task automatic run_access(input string name, input bit st, input int f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] memval, input int hold);
        bit          ill;
        logic [31:0] exp_rd;
        ill    = ref_illegal(st, f3);
        exp_rd = (st || ill) ? 32'h0 : ref_load(f3, memval);

        check({name, ".ready_idle"}, {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = 3'(f3);
        req_addr   = addr;
        req_wdata  = wdata;
        mem_out    = memval;
        resp_ready = 1'b0;
        step();                       // acceptance edge t
        req_valid  = 1'b0;
        req_wdata  = ~wdata;

        if (ill) begin
            check({name, ".err_valid_t"}, {31'h0, resp_valid}, 32'd1);
            check({name, ".err_flag"},    {31'h0, resp_err},   32'd1);
            check({name, ".err_wren"},    {31'h0, mem_wren},   32'd0);
        end else begin
            check({name, ".acc_addr"},  mem_address,          addr);
            check({name, ".acc_width"}, {30'h0, mem_width},   ref_width(f3));
            check({name, ".acc_wren"},  {31'h0, mem_wren},    {31'h0, st});
            check({name, ".acc_valid"}, {31'h0, resp_valid},  32'd0);
            if (st) check({name, ".acc_min"}, mem_in, wdata);
            step();                   // edge t+1
            check({name, ".t1_wren"}, {31'h0, mem_wren}, 32'd0);
            if (st) begin
                check({name, ".st_valid_t1"}, {31'h0, resp_valid}, 32'd1);
                check({name, ".st_min_hold"}, mem_in, wdata);
            end else begin
                check({name, ".rd_valid_t1"}, {31'h0, resp_valid}, 32'd0);
                check({name, ".rd_addr_hold"}, mem_address, addr);
                check({name, ".rd_width_hold"}, {30'h0, mem_width}, ref_width(f3));
                step();               // edge t+2
                check({name, ".ld_valid_t2"}, {31'h0, resp_valid}, 32'd1);
            end
            check({name, ".noerr"}, {31'h0, resp_err}, 32'd0);
        end
        check({name, ".rdata"},      resp_rdata,           exp_rd);
        check({name, ".ready_busy"}, {31'h0, req_ready},   32'd0);

        for (int i = 0; i < hold; i++) begin
            step();
            check({name, ".hold_valid"}, {31'h0, resp_valid}, 32'd1);
            check({name, ".hold_rdata"}, resp_rdata,          exp_rd);
            check({name, ".hold_err"},   {31'h0, resp_err},   {31'h0, ill});
            check({name, ".hold_ready"}, {31'h0, req_ready},  32'd0);
            check({name, ".hold_wren"},  {31'h0, mem_wren},   32'd0);
        end

        resp_ready = 1'b1;
        step();                       // response handshake edge
        resp_ready = 1'b0;
        check({name, ".done_valid"}, {31'h0, resp_valid}, 32'd0);
        check({name, ".done_ready"}, {31'h0, req_ready},  32'd1);
        $display("txn %s store=%0d funct3=%0d addr=%h wdata=%h memout=%h rdata=%h err=%0d",
                 name, st, f3, addr, wdata, memval, exp_rd, ill);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        mem_out    = 32'h0;

        #2;
        check("rst.ready",  {31'h0, req_ready},  32'd1);
        check("rst.valid",  {31'h0, resp_valid}, 32'd0);
        check("rst.err",    {31'h0, resp_err},   32'd0);
        check("rst.rdata",  resp_rdata,          32'h0);
        check("rst.wren",   {31'h0, mem_wren},   32'd0);
        check("rst.addr",   mem_address,         32'h0);
        check("rst.min",    mem_in,              32'h0);
        check("rst.width",  {30'h0, mem_width},  32'd3);
        #10 rst = 1'b0;
        step();

        // Directed accesses from the requirement examples
        run_access("lb_103",  1'b0, 0, 32'h0000_0103, 32'h0,         32'h8012_3456, 0);
        run_access("lhu_2",   1'b0, 5, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 1);
        run_access("lh_2",    1'b0, 1, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0);
        run_access("sw_2",    1'b1, 2, 32'h0000_0002, 32'hDEAD_BEEF, 32'h1111_1111, 0);
        run_access("ld_011",  1'b0, 3, 32'h0000_0040, 32'h0,         32'hFFFF_FFFF, 0);
        run_access("lw_bp",   1'b0, 2, 32'h0000_1000, 32'h0,         32'hCAFE_F00D, 4);
        run_access("st_bu",   1'b1, 4, 32'h0000_0010, 32'h1234_5678, 32'h0,         2);
        run_access("lbu_ff",  1'b0, 4, 32'h0000_0007, 32'h0,         32'hFF00_0000, 0);

        // Reset in the ACCESS cycle of a byte store abandons it
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0055;
        req_wdata  = 32'h0000_00A5;
        step();
        req_valid = 1'b0;
        check("sb_rst.wren_access", {31'h0, mem_wren}, 32'd1);
        rst = 1'b1;
        #1;
        check("sb_rst.wren_async", {31'h0, mem_wren},   32'd0);
        check("sb_rst.ready",      {31'h0, req_ready},  32'd1);
        check("sb_rst.valid",      {31'h0, resp_valid}, 32'd0);
        check("sb_rst.addr",       mem_address,         32'h0);
        check("sb_rst.width",      {30'h0, mem_width},  32'd3);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sb_rst.no_resp",  {31'h0, resp_valid}, 32'd0);
            check("sb_rst.idle",     {31'h0, req_ready},  32'd1);
            check("sb_rst.no_wren",  {31'h0, mem_wren},   32'd0);
        end
        $display("txn sb_rst store=1 funct3=0 addr=00000055 abandoned by reset");

        // Randomized accesses, including illegal encodings
        for (int n = 0; n < 24; n++) begin
            run_access($sformatf("rnd%0d", n),
                       bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)),
                       32'($urandom), 32'($urandom), 32'($urandom),
                       int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
